// File: rtl/tx_pkt_sched.sv
// tx_pkt_sched: arbitrates two requesters and sends each packet (header, payload hi, payload lo) to a byte UART.
// Header trmt 1 cycle after grant, each later byte 1 cycle after tx_done in WAIT; requesters hold req while busy.
module tx_pkt_sched #(
   parameter logic [7:0] HDR_CH0 = 8'hA5,
   parameter logic [7:0] HDR_CH1 = 8'h5A
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [15:0] data0,
   input  logic [15:0] data1,
   output logic        ack0,
   output logic        ack1,
   output logic        trmt,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   output logic        busy,
   output logic        pkt_done
);

   typedef enum logic [1:0] {IDLE, SEND, GUARD, WAIT} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  idx;
   logic        last_grant;
   logic        chan;
   logic [15:0] payload;
   logic        grant;
   logic        win;
   logic        byte_fin;
   logic        pkt_fin;

   // On contention the channel that was not served last time wins.
   assign grant    = (state == IDLE) && (req0 || req1);
   assign win      = (req0 && req1) ? ~last_grant : req1;
   assign byte_fin = (state == WAIT) && tx_done;
   assign pkt_fin  = byte_fin && (idx == 2'd2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req0 || req1) state_nxt = SEND;
         SEND:    state_nxt = GUARD;
         // tx_done may still show the previous byte's level here, so it is not looked at.
         GUARD:   state_nxt = WAIT;
         WAIT:    if (tx_done) state_nxt = (idx == 2'd2) ? IDLE : SEND;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= 2'd0;
         last_grant <= 1'b1;
         chan       <= 1'b0;
         payload    <= 16'h0000;
         tx_data    <= 8'h00;
         pkt_done   <= 1'b0;
      end else begin
         pkt_done <= pkt_fin;
         if (grant) begin
            last_grant <= win;
            chan       <= win;
            payload    <= win ? data1 : data0;
            idx        <= 2'd0;
            tx_data    <= win ? HDR_CH1 : HDR_CH0;
         end else if (byte_fin && !pkt_fin) begin
            idx     <= idx + 2'd1;
            tx_data <= (idx == 2'd0) ? payload[15:8] : payload[7:0];
         end
      end
   end

   // SEND with idx 0 is the one cycle right after the grant edge.
   always_comb begin
      trmt = 1'b0;
      ack0 = 1'b0;
      ack1 = 1'b0;
      busy = (state != IDLE);
      if (state == SEND) begin
         trmt = 1'b1;
         ack0 = (idx == 2'd0) && !chan;
         ack1 = (idx == 2'd0) && chan;
      end
   end

   a_ack_excl: assert property (@(posedge clk) disable iff (rst) !(ack0 && ack1));
   a_ack_pd:   assert property (@(posedge clk) disable iff (rst) !(pkt_done && (ack0 || ack1)));
   a_trmt_1:   assert property (@(posedge clk) disable iff (rst) trmt |=> !trmt);

endmodule

// File: tb/tb_tx_pkt_sched.sv
// Bench for tx_pkt_sched: directed scenarios plus random traffic, every cycle compared with a packet-level model.
module tb_tx_pkt_sched;
   localparam logic [7:0] H0 = 8'hA5;
   localparam logic [7:0] H1 = 8'h5A;

   logic        clk = 1'b0;
   logic        rst, req0, req1, tx_done;
   logic [15:0] data0, data1;
   logic        ack0, ack1, trmt, busy, pkt_done;
   logic [7:0]  tx_data;

   tx_pkt_sched #(.HDR_CH0(H0), .HDR_CH1(H1)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
      .ack0(ack0), .ack1(ack1), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
      .busy(busy), .pkt_done(pkt_done));

   always #10 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   bit chk_en = 0;
   bit keep0 = 0;
   bit keep1 = 0;

   // Reference model: idle/active flag, queue of bytes still to send, cycles since last trmt.
   bit         m_act = 0;
   bit         m_last = 1;
   int         m_since = 0;
   logic [7:0] m_q[$];
   logic       e_trmt, e_ack0, e_ack1, e_pd, e_busy;
   logic [7:0] e_txd;

   int u_cnt = 0;
   bit prev_trmt = 0;

   logic [7:0] bytes_q[$];
   int trmt_cyc[$], pd_cyc[$], ack_cyc[$], ack_ch[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      else n_pass++;
   endtask

   function automatic logic [7:0] byte_at(input int i);
      return (bytes_q.size() > i) ? bytes_q[i] : 8'hxx;
   endfunction

   task automatic clear_logs();
      bytes_q.delete(); trmt_cyc.delete(); pd_cyc.delete(); ack_cyc.delete(); ack_ch.delete();
   endtask

   // Observe cycle outputs, log events, run the requester hand-off and the UART model.
   task automatic tick();
      @(posedge clk); #1; cyc++;
      if (chk_en) begin
         check("trmt", 32'(trmt), 32'(e_trmt));
         check("ack0", 32'(ack0), 32'(e_ack0));
         check("ack1", 32'(ack1), 32'(e_ack1));
         check("pkt_done", 32'(pkt_done), 32'(e_pd));
         check("busy", 32'(busy), 32'(e_busy));
         check("tx_data", 32'(tx_data), 32'(e_txd));
      end
      if (trmt === 1'b1) begin bytes_q.push_back(tx_data); trmt_cyc.push_back(cyc); end
      if (pkt_done === 1'b1) pd_cyc.push_back(cyc);
      if (ack0 === 1'b1) begin
         ack_cyc.push_back(cyc); ack_ch.push_back(0);
         if (!keep0) begin req0 = 1'b0; data0 = 16'($urandom); end
      end
      if (ack1 === 1'b1) begin
         ack_cyc.push_back(cyc); ack_ch.push_back(1);
         if (!keep1) begin req1 = 1'b0; data1 = 16'($urandom); end
      end
      if (prev_trmt) begin
         u_cnt = $urandom_range(3, 12);
         tx_done = 1'($urandom_range(0, 1));   // sometimes leave the old level up through GUARD
      end else if (u_cnt > 0) begin
         u_cnt--;
         tx_done = (u_cnt == 0);
      end
      prev_trmt = (trmt === 1'b1);
   endtask

   // Apply this cycle's inputs to the model; produces expected outputs for the next cycle.
   task automatic commit();
      logic        w;
      logic [15:0] p;
      e_trmt = 0; e_ack0 = 0; e_ack1 = 0; e_pd = 0;
      if (rst) begin
         m_act = 0; m_last = 1; m_since = 0; m_q.delete(); e_txd = 8'h00;
      end else if (!m_act) begin
         if (req0 || req1) begin
            w = (req0 && req1) ? !m_last : req1;
            m_last = w;
            p = w ? data1 : data0;
            m_q.delete(); m_q.push_back(p[15:8]); m_q.push_back(p[7:0]);
            e_txd = w ? H1 : H0;
            e_trmt = 1; e_ack0 = !w; e_ack1 = w;
            m_act = 1; m_since = 0;
         end
      end else if (m_since >= 2 && tx_done) begin
         if (m_q.size() > 0) begin
            e_txd = m_q.pop_front(); e_trmt = 1; m_since = 0;
         end else begin
            m_act = 0; e_pd = 1;
         end
      end else begin
         m_since++;
      end
      e_busy = m_act;
   endtask

   task automatic run_cycles(input int n);
      repeat (n) begin tick(); commit(); end
   endtask

   task automatic run_until_pd(input int n, input int budget);
      int start;
      int k;
      start = pd_cyc.size(); k = 0;
      while (pd_cyc.size() < start + n && k < budget) begin tick(); commit(); k++; end
      if (pd_cyc.size() < start + n) check("pd_timeout", 32'(pd_cyc.size()), 32'(start + n));
   endtask

   task automatic run_until_trmt(input int n, input int budget);
      int k;
      k = 0;
      while (trmt_cyc.size() < n && k < budget) begin tick(); commit(); k++; end
      if (trmt_cyc.size() < n) check("trmt_timeout", 32'(trmt_cyc.size()), 32'(n));
   endtask

   task automatic run_until_ack(input int n, input int budget);
      int k;
      k = 0;
      while (ack_cyc.size() < n && k < budget) begin tick(); commit(); k++; end
      if (ack_cyc.size() < n) check("ack_timeout", 32'(ack_cyc.size()), 32'(n));
   endtask

   task automatic check_pkt(input string tag, input int base, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2);
      check({tag, "_hdr"}, 32'(byte_at(base)), 32'(b0));
      check({tag, "_hi"}, 32'(byte_at(base + 1)), 32'(b1));
      check({tag, "_lo"}, 32'(byte_at(base + 2)), 32'(b2));
   endtask

   initial begin
      int raise_cyc;
      int pd0;
      rst = 1; req0 = 0; req1 = 0; data0 = 0; data1 = 0; tx_done = 1;

      tick(); commit(); tick(); commit();
      chk_en = 1;
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_txd", 32'(tx_data), 32'h00);
      check("rst_pd", 32'(pkt_done), 32'd0);
      rst = 0; commit();

      // Single packet, latency and byte order
      clear_logs();
      tick(); req0 = 1; data0 = 16'h1234; raise_cyc = cyc; commit();
      run_until_pd(1, 300); run_cycles(3);
      check_pkt("single", 0, H0, 8'h12, 8'h34);
      check("single_ntrmt", 32'(bytes_q.size()), 32'd3);
      check("single_nack", 32'(ack_cyc.size()), 32'd1);
      check("single_ack_lat", 32'(ack_cyc.size() > 0 ? ack_cyc[0] : -1), 32'(raise_cyc + 1));
      check("single_trmt_lat", 32'(trmt_cyc.size() > 0 ? trmt_cyc[0] : -1), 32'(raise_cyc + 1));
      check("single_npd", 32'(pd_cyc.size()), 32'd1);
      check("single_busy_after", 32'(busy), 32'd0);

      // Contention straight after reset: channel 0 first, back-to-back second packet
      tick(); rst = 1; commit();
      clear_logs();
      tick(); rst = 0; req0 = 1; req1 = 1; data0 = 16'hBEEF; data1 = 16'hCAFE; commit();
      run_until_pd(2, 600); run_cycles(3);
      check_pkt("cont_p0", 0, H0, 8'hBE, 8'hEF);
      check_pkt("cont_p1", 3, H1, 8'hCA, 8'hFE);
      check("cont_first_ack", 32'(ack_ch.size() > 0 ? ack_ch[0] : -1), 32'd0);
      check("cont_second_ack", 32'(ack_ch.size() > 1 ? ack_ch[1] : -1), 32'd1);
      check("cont_b2b", 32'(trmt_cyc.size() > 3 ? trmt_cyc[3] : -1),
            32'(pd_cyc.size() > 0 ? pd_cyc[0] + 1 : -2));

      // Fairness with both requests held for four packets
      clear_logs(); keep0 = 1; keep1 = 1;
      tick(); req0 = 1; req1 = 1; data0 = 16'h0102; data1 = 16'h0304; commit();
      run_until_ack(4, 1200);
      keep0 = 0; keep1 = 0;
      tick(); req0 = 0; req1 = 0; commit();
      run_until_pd(1, 300); run_cycles(3);
      for (int i = 0; i < 4; i++) begin
         check("fair_grant", 32'(ack_ch.size() > i ? ack_ch[i] : -1), 32'(i % 2));
         check("fair_hdr", 32'(byte_at(3 * i)), 32'((i % 2) ? H1 : H0));
      end
      check("fair_nack", 32'(ack_cyc.size()), 32'd4);

      // Late request arrives while channel 0 is busy
      clear_logs();
      tick(); req0 = 1; data0 = 16'h7788; commit();
      run_cycles(4);
      tick(); req1 = 1; data1 = 16'h99AA; commit();
      run_until_pd(2, 600); run_cycles(3);
      check("late_order", 32'(ack_ch.size() > 1 ? ack_ch[1] : -1), 32'd1);
      check("late_ack1", 32'(ack_cyc.size() > 1 ? ack_cyc[1] : -1),
            32'(pd_cyc.size() > 0 ? pd_cyc[0] + 1 : -2));
      check_pkt("late_p1", 3, H1, 8'h99, 8'hAA);

      // Reset while waiting on byte 1
      clear_logs();
      tick(); req0 = 1; data0 = 16'h55AA; commit();
      run_until_trmt(2, 300);
      run_cycles(2);
      tick(); rst = 1; commit();
      tick();
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_trmt", 32'(trmt), 32'd0);
      rst = 0; commit();
      pd0 = pd_cyc.size();
      run_cycles(30);
      check("midrst_no_pd", 32'(pd_cyc.size()), 32'(pd0));
      clear_logs();
      tick(); req0 = 1; data0 = 16'h0F0F; commit();
      run_until_pd(1, 300); run_cycles(3);
      check_pkt("midrst_new", 0, H0, 8'h0F, 8'h0F);

      // Random traffic: reactive requesters, occasional abandoned requests and resets
      for (int i = 0; i < 3000; i++) begin
         tick();
         rst = ($urandom_range(0, 499) == 0);
         if (!req0) begin
            if ($urandom_range(0, 3) == 0) req0 = 1;
            data0 = 16'($urandom);
         end else if ($urandom_range(0, 79) == 0) begin
            req0 = 0;
         end
         if (!req1) begin
            if ($urandom_range(0, 3) == 0) req1 = 1;
            data1 = 16'($urandom);
         end else if ($urandom_range(0, 79) == 0) begin
            req1 = 0;
         end
         commit();
      end
      tick(); rst = 0; req0 = 0; req1 = 0; commit();
      run_cycles(150);
      check("drain_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
